// File: rtl/hawk_cmpresn_mngr.sv
// rtl/hawk_cmpresn_mngr.sv - victim-page compression sequencer for the hawk read manager
package hacd_pkg;
   localparam int HACD_AXI4_DATA_WIDTH = 512;
   localparam int HACD_AXI4_ADDR_WIDTH = 32;
   localparam int WAY_W                = HACD_AXI4_ADDR_WIDTH - 12;
   localparam int TOL_IDX_W            = 16;
   localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] TOL_BASE = 32'h0010_0000;
   localparam logic [1:0] STS_UNCOMP = 2'd1;
   localparam logic [1:0] STS_COMP   = 2'd2;

   typedef struct packed {
      logic [TOL_IDX_W-1:0] uncompListHead;
      logic [TOL_IDX_W-1:0] uncompListTail;
      logic [TOL_IDX_W-1:0] compListHead;
      logic [TOL_IDX_W-1:0] compListTail;
   } hawk_tol_ht_t;

   typedef struct packed {
      logic arready;
   } axi_rd_rdypkt_t;

   typedef struct packed {
      logic                            rvalid;
      logic                            rlast;
      logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
      logic [1:0]                      rresp;
   } axi_rd_resppkt_t;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [7:0]                      arlen;
   } axi_rd_pld_t;

   typedef struct packed {
      logic             tbl_update;
      logic [WAY_W-1:0] way;
      logic [1:0]       status;
      logic [13:0]      comp_size;
   } tol_updpkt_t;
endpackage

module hawk_cmpresn_mngr
   import hacd_pkg::*;
(
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            cmpresn_trigger,
   input  hawk_tol_ht_t                    tol_HT,
   input  axi_rd_rdypkt_t                  rd_rdypkt,
   input  axi_rd_resppkt_t                 rd_resppkt,
   input  logic                            rdfifo_full,
   input  logic                            rdfifo_empty,
   input  logic                            comp_done,
   input  logic [13:0]                     comp_size,
   input  logic                            pgwr_mngr_ready,
   input  logic                            tbl_update_done,
   output axi_rd_pld_t                     n_comp_axireq,
   output logic                            n_comp_req_arvalid,
   output logic                            n_comp_rready,
   output logic [HACD_AXI4_DATA_WIDTH-1:0] n_comp_rdata,
   output tol_updpkt_t                     n_comp_tol_updpkt,
   output logic                            comp_start,
   output logic                            rdfifo_wrptr_rst,
   output logic                            rdfifo_rdptr_rst,
   output logic                            cmpresn_done,
   output logic [WAY_W-1:0]                cmpresn_freeWay
);

   localparam logic [7:0] PAGE_ARLEN = 8'(4096 / (HACD_AXI4_DATA_WIDTH / 8) - 1);

   typedef enum logic [3:0] {
      IDLE, RD_VICTIM, WAIT_VICTIM, FIFO_RST, RD_PAGE, WAIT_PAGE,
      COMP, WAIT_COMP, TBL_UPD, WAIT_UPD, DONE, ERROR
   } state_t;

   state_t                          state, state_nx;
   logic [WAY_W-1:0]                way_q;
   logic [HACD_AXI4_DATA_WIDTH-1:0] rdata_q;
   logic [13:0]                     size_q;
   logic                            latch_victim, latch_size, abort;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] entry_addr;

   // Only the uncompressed-list head selects the victim; the rest is informational here.
   logic unused_inputs;
   assign unused_inputs = ^{tol_HT.uncompListTail, tol_HT.compListHead,
                            tol_HT.compListTail, rdfifo_empty};

   // TOL entries are one data beat (64 bytes) each, packed from TOL_BASE.
   assign entry_addr = TOL_BASE + (HACD_AXI4_ADDR_WIDTH'(tol_HT.uncompListHead) << 6);

   assign cmpresn_freeWay = way_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nx;
   end

   // Victim entry, victim way and compressed size are held across the operation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         way_q   <= '0;
         rdata_q <= '0;
         size_q  <= '0;
      end else begin
         if (latch_victim) begin
            way_q   <= rd_resppkt.rdata[WAY_W-1:0];
            rdata_q <= rd_resppkt.rdata;
         end
         if (latch_size) size_q <= comp_size;
      end
   end

   // Next-state and next-value outputs; a dropped trigger mid-operation cancels every pulse.
   always_comb begin
      state_nx           = state;
      n_comp_axireq      = '0;
      n_comp_req_arvalid = 1'b0;
      n_comp_rready      = 1'b1;
      n_comp_rdata       = rdata_q;
      n_comp_tol_updpkt  = '{tbl_update: 1'b0, way: way_q, status: STS_COMP, comp_size: size_q};
      comp_start         = 1'b0;
      rdfifo_wrptr_rst   = 1'b0;
      rdfifo_rdptr_rst   = 1'b0;
      cmpresn_done       = 1'b0;
      latch_victim       = 1'b0;
      latch_size         = 1'b0;
      abort              = !cmpresn_trigger && !(state inside {IDLE, DONE, ERROR});

      case (state)
         IDLE: if (cmpresn_trigger) state_nx = RD_VICTIM;
         RD_VICTIM: if (rd_rdypkt.arready) begin
            n_comp_axireq.addr  = entry_addr;
            n_comp_axireq.arlen = 8'd0;
            n_comp_req_arvalid  = 1'b1;
            state_nx            = WAIT_VICTIM;
         end
         WAIT_VICTIM: if (rd_resppkt.rvalid && rd_resppkt.rlast) begin
            if (rd_resppkt.rresp == 2'b00) begin
               latch_victim = 1'b1;
               n_comp_rdata = rd_resppkt.rdata;
               state_nx     = FIFO_RST;
            end else begin
               state_nx = ERROR;
            end
         end
         FIFO_RST: begin
            rdfifo_wrptr_rst = 1'b1;
            rdfifo_rdptr_rst = 1'b1;
            state_nx         = RD_PAGE;
         end
         RD_PAGE: if (rd_rdypkt.arready) begin
            n_comp_axireq.addr  = {way_q, 12'h000};
            n_comp_axireq.arlen = PAGE_ARLEN;
            n_comp_req_arvalid  = 1'b1;
            state_nx            = WAIT_PAGE;
         end
         WAIT_PAGE: begin
            n_comp_rready = !rdfifo_full;
            if (rd_resppkt.rvalid && !rdfifo_full) begin
               if (rd_resppkt.rresp != 2'b00) state_nx = ERROR;
               else if (rd_resppkt.rlast)     state_nx = COMP;
            end
         end
         COMP: begin
            comp_start = 1'b1;
            state_nx   = WAIT_COMP;
         end
         WAIT_COMP: if (comp_done) begin
            latch_size = 1'b1;
            state_nx   = TBL_UPD;
         end
         TBL_UPD: if (pgwr_mngr_ready) begin
            n_comp_tol_updpkt.tbl_update = 1'b1;
            state_nx                     = WAIT_UPD;
         end
         WAIT_UPD: if (tbl_update_done) state_nx = DONE;
         DONE: begin
            cmpresn_done = 1'b1;
            state_nx     = IDLE;
         end
         ERROR:   state_nx = ERROR;
         default: state_nx = IDLE;
      endcase

      if (abort) begin
         state_nx                     = IDLE;
         n_comp_axireq                = '0;
         n_comp_req_arvalid           = 1'b0;
         n_comp_rdata                 = rdata_q;
         n_comp_tol_updpkt.tbl_update = 1'b0;
         comp_start                   = 1'b0;
         rdfifo_wrptr_rst             = 1'b0;
         rdfifo_rdptr_rst             = 1'b0;
         latch_victim                 = 1'b0;
         latch_size                   = 1'b0;
      end
   end

endmodule

// File: tb/tb_hawk_cmpresn_mngr.sv
// tb/tb_hawk_cmpresn_mngr.sv - randomized directed-sequence bench for hawk_cmpresn_mngr
module tb_hawk_cmpresn_mngr;
   import hacd_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic cmpresn_trigger;
   hawk_tol_ht_t tol_HT;
   axi_rd_rdypkt_t rd_rdypkt;
   axi_rd_resppkt_t rd_resppkt;
   logic rdfifo_full, rdfifo_empty, comp_done, pgwr_mngr_ready, tbl_update_done;
   logic [13:0] comp_size;
   axi_rd_pld_t n_comp_axireq;
   logic n_comp_req_arvalid, n_comp_rready;
   logic [HACD_AXI4_DATA_WIDTH-1:0] n_comp_rdata;
   tol_updpkt_t n_comp_tol_updpkt;
   logic comp_start, rdfifo_wrptr_rst, rdfifo_rdptr_rst, cmpresn_done;
   logic [WAY_W-1:0] cmpresn_freeWay;

   int compared = 0, mismatched = 0;
   int n_starts = 0, n_dones = 0, n_arv = 0;
   int exp_starts = 0, exp_dones = 0, exp_arv = 0;

   localparam int BEATS = 4096 / (HACD_AXI4_DATA_WIDTH / 8);

   hawk_cmpresn_mngr dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cmpresn_trigger(cmpresn_trigger), .tol_HT(tol_HT),
      .rd_rdypkt(rd_rdypkt), .rd_resppkt(rd_resppkt), .rdfifo_full(rdfifo_full),
      .rdfifo_empty(rdfifo_empty), .comp_done(comp_done), .comp_size(comp_size),
      .pgwr_mngr_ready(pgwr_mngr_ready), .tbl_update_done(tbl_update_done),
      .n_comp_axireq(n_comp_axireq), .n_comp_req_arvalid(n_comp_req_arvalid),
      .n_comp_rready(n_comp_rready), .n_comp_rdata(n_comp_rdata),
      .n_comp_tol_updpkt(n_comp_tol_updpkt), .comp_start(comp_start),
      .rdfifo_wrptr_rst(rdfifo_wrptr_rst), .rdfifo_rdptr_rst(rdfifo_rdptr_rst),
      .cmpresn_done(cmpresn_done), .cmpresn_freeWay(cmpresn_freeWay)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (comp_start)         n_starts++;
         if (cmpresn_done)       n_dones++;
         if (n_comp_req_arvalid) n_arv++;
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_arvalid", n_comp_req_arvalid, 1'b0);
      chk("rst_rready", n_comp_rready, 1'b1);
      chk("rst_axireq", n_comp_axireq, '0);
      chk("rst_rdata", n_comp_rdata, '0);
      chk("rst_freeway", cmpresn_freeWay, '0);
      chk("rst_tbl_update", n_comp_tol_updpkt.tbl_update, 1'b0);
      chk("rst_size", n_comp_tol_updpkt.comp_size, '0);
      chk("rst_pulses", {comp_start, rdfifo_wrptr_rst, rdfifo_rdptr_rst, cmpresn_done}, 4'b0);
   endtask

   // mode 0 normal, 1 victim read error, 2 reset in WAIT_COMP, 3 trigger drop in WAIT_PAGE
   task automatic run_op(input int mode, input bit directed);
      logic [TOL_IDX_W-1:0] head;
      logic [WAY_W-1:0] way;
      logic [13:0] size;
      logic [511:0] entry;
      int d, acc, cyc;
      bit full;
      head = directed ? 16'd5 : 16'($urandom);
      way  = directed ? 20'h80123 : 20'($urandom);
      size = directed ? 14'h400 : 14'($urandom);
      for (int w = 0; w < 16; w++) entry[w*32 +: 32] = $urandom;
      entry[WAY_W-1:0] = way;

      tol_HT.uncompListHead = head;
      cmpresn_trigger = 1'b1;
      settle();
      tick();
      d = directed ? 10 : int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
         settle(); chk("victim_ar_hold", n_comp_req_arvalid, 1'b0); tick();
      end
      rd_rdypkt.arready = 1'b1;
      settle();
      chk("victim_arvalid", n_comp_req_arvalid, 1'b1);
      chk("victim_addr", n_comp_axireq.addr, TOL_BASE + 32'(head) * 64);
      chk("victim_arlen", n_comp_axireq.arlen, 8'd0);
      exp_arv++;
      tick();
      rd_rdypkt.arready = 1'b0;
      settle();
      chk("victim_ar_once", n_comp_req_arvalid, 1'b0);

      d = int'($urandom_range(0, 2));
      for (int i = 0; i < d; i++) begin
         settle(); chk("victim_wait_rready", n_comp_rready, 1'b1); tick();
      end
      rd_resppkt = '{rvalid: 1'b1, rlast: 1'b1, rdata: entry, rresp: (mode == 1) ? 2'd2 : 2'd0};
      settle();
      if (mode == 1) begin
         tick();
         rd_resppkt.rvalid = 1'b0;
         for (int i = 0; i < 8; i++) begin
            rd_rdypkt.arready = 1'($urandom); comp_done = 1'b1; pgwr_mngr_ready = 1'b1;
            tbl_update_done = 1'b1;
            settle();
            chk("err_quiet", {comp_start, cmpresn_done, n_comp_req_arvalid, rdfifo_wrptr_rst}, 4'b0);
            chk("err_rready", n_comp_rready, 1'b1);
            tick();
         end
         {comp_done, pgwr_mngr_ready, tbl_update_done} = 3'b0;
         rd_rdypkt.arready = 1'b0;
         return;
      end
      chk("victim_rdata", n_comp_rdata, entry);
      tick();
      rd_resppkt.rvalid = 1'b0;
      settle();
      chk("fifo_rst", {rdfifo_wrptr_rst, rdfifo_rdptr_rst}, 2'b11);
      chk("rdata_held", n_comp_rdata, entry);
      tick();

      d = int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
         settle();
         chk("page_ar_hold", {n_comp_req_arvalid, rdfifo_wrptr_rst}, 2'b0);
         tick();
      end
      rd_rdypkt.arready = 1'b1;
      settle();
      chk("page_arvalid", n_comp_req_arvalid, 1'b1);
      chk("page_addr", n_comp_axireq.addr, 32'(way) * 4096);
      chk("page_arlen", n_comp_axireq.arlen, 8'(BEATS - 1));
      exp_arv++;
      tick();
      rd_rdypkt.arready = 1'b0;

      acc = 0;
      cyc = 0;
      while (acc < BEATS && cyc < 1000) begin
         full = directed ? (cyc >= 10 && cyc <= 14) : ($urandom_range(0, 7) == 0);
         rdfifo_full = full;
         rd_resppkt.rvalid = 1'b1;
         rd_resppkt.rlast  = (acc == BEATS - 1);
         rd_resppkt.rdata  = {16{$urandom}};
         rd_resppkt.rresp  = 2'd0;
         settle();
         chk("page_rready", n_comp_rready, !full);
         if (mode == 3 && acc == 20) begin
            cmpresn_trigger = 1'b0;
            settle();
            chk("abort_no_start", comp_start, 1'b0);
            tick();
            rd_resppkt.rvalid = 1'b0; rdfifo_full = 1'b0; rd_rdypkt.arready = 1'b1;
            settle();
            chk("abort_idle", {n_comp_req_arvalid, n_comp_rready}, 2'b01);
            rd_rdypkt.arready = 1'b0;
            return;
         end
         if (!full) acc++;
         cyc++;
         tick();
      end
      chk("page_beats", acc, BEATS);
      rd_resppkt.rvalid = 1'b0;
      rdfifo_full = 1'b0;

      settle();
      chk("comp_start", comp_start, 1'b1);
      exp_starts++;
      tick();
      d = int'($urandom_range(1, 4));
      for (int i = 0; i < d; i++) begin
         settle(); chk("comp_start_once", comp_start, 1'b0); tick();
      end
      if (mode == 2) begin
         #2 rst_ni = 1'b0;
         #1 chk_reset();
         cmpresn_trigger = 1'b0;
         return;
      end
      comp_done = 1'b1; comp_size = size;
      settle();
      tick();
      comp_done = 1'b0; comp_size = 14'($urandom);

      d = directed ? 5 : int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
         settle(); chk("upd_hold", n_comp_tol_updpkt.tbl_update, 1'b0); tick();
      end
      pgwr_mngr_ready = 1'b1;
      settle();
      chk("upd_pulse", n_comp_tol_updpkt.tbl_update, 1'b1);
      chk("upd_way", n_comp_tol_updpkt.way, way);
      chk("upd_status", n_comp_tol_updpkt.status, STS_COMP);
      chk("upd_size", n_comp_tol_updpkt.comp_size, size);
      tick();
      pgwr_mngr_ready = 1'b0;
      d = int'($urandom_range(1, 3));
      for (int i = 0; i < d; i++) begin
         settle(); chk("upd_once", n_comp_tol_updpkt.tbl_update, 1'b0); tick();
      end
      tbl_update_done = 1'b1;
      settle();
      chk("no_early_done", cmpresn_done, 1'b0);
      tick();
      tbl_update_done = 1'b0;
      cmpresn_trigger = 1'b0;
      settle();
      chk("done_pulse", cmpresn_done, 1'b1);
      chk("done_freeway", cmpresn_freeWay, way);
      exp_dones++;
      tick();
      settle();
      chk("done_once", cmpresn_done, 1'b0);
      chk("freeway_hold", cmpresn_freeWay, way);
   endtask

   initial begin
      rst_ni = 1'b0; cmpresn_trigger = 1'b0; tol_HT = '0; rd_rdypkt = '0; rd_resppkt = '0;
      rdfifo_full = 1'b0; rdfifo_empty = 1'b1; comp_done = 1'b0; comp_size = '0;
      pgwr_mngr_ready = 1'b0; tbl_update_done = 1'b0;
      repeat (3) tick();
      settle();
      chk_reset();
      rst_ni = 1'b1;
      settle();
      chk_reset();

      run_op(0, 1'b1);
      repeat (6) run_op(0, 1'b0);
      run_op(3, 1'b0);
      run_op(0, 1'b0);

      run_op(1, 1'b0);
      rst_ni = 1'b0;
      settle();
      chk_reset();
      tick();
      rst_ni = 1'b1;
      run_op(0, 1'b0);

      run_op(2, 1'b0);
      tick();
      rst_ni = 1'b1;
      settle();
      chk_reset();
      run_op(0, 1'b0);

      repeat (3) tick();
      chk("total_comp_start", n_starts, exp_starts);
      chk("total_done", n_dones, exp_dones);
      chk("total_arvalid", n_arv, exp_arv);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
